bcd_counter_ctrl: RTL

Run controller for the 4-digit BCD counter (`full_bcd_counter`). It turns start/stop/clear/lap command pulses into the counter's count enable and reset. A prescaler sets the count rate, and the controller stops counting when the counter reaches a programmable BCD terminal value. It sits between the front-panel debouncers and the counter, forming a stopwatch/event-timer subsystem.

---
 rtl/bcd_counter_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/bcd_counter_ctrl.sv
// Run controller for a 4-digit BCD counter: converts start/stop/clear/lap pulses
// into a prescaled count enable, counter reset, lap capture and terminal stop.
module bcd_counter_ctrl #(
    parameter int DIV   = 50000,
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    input  logic [15:0] limit,
    input  logic [3:0]  bcd1,
    input  logic [3:0]  bcd2,
    input  logic [3:0]  bcd3,
    input  logic [3:0]  bcd4,
    output logic        cnt_en,
    output logic        cnt_rst,
    output logic [15:0] lap_bcd,
    output logic        lap_valid,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    state_t           state;
    logic [DIV_W-1:0] presc;
    logic [15:0]      digits;
    logic             limit_is_bcd;
    logic             match;

    assign digits = {bcd4, bcd3, bcd2, bcd1};

    // A limit with any digit above 9 can never be reached by a BCD counter.
    assign limit_is_bcd = (limit[15:12] <= 4'd9) && (limit[11:8] <= 4'd9) &&
                          (limit[7:4]   <= 4'd9) && (limit[3:0]  <= 4'd9);

    assign match = (state == RUN) && (limit != 16'h0000) && limit_is_bcd &&
                   (digits == limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            cnt_en    <= 1'b0;
            cnt_rst   <= 1'b1;
            lap_bcd   <= 16'h0000;
            lap_valid <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_rst <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                presc     <= '0;
                cnt_rst   <= 1'b1;
                lap_bcd   <= 16'h0000;
                lap_valid <= 1'b0;
                running   <= 1'b0;
                done      <= 1'b0;
            end else begin
                if (lap && (state == RUN || state == PAUSE)) begin
                    lap_bcd   <= digits;
                    lap_valid <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state   <= RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        // stop and match both freeze the prescaler and drop any pending tick
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (match) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (presc == PRESC_LAST) begin
                            cnt_en <= 1'b1;
                            presc  <= '0;
                        end else begin
                            presc <= presc + DIV_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (start && !stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
